// File: rtl/ahblite_uart_if.sv
// AHB-Lite slave-side bus bundle for the UART; signal names follow the SoC bus.
interface ahblite_uart_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic [3:0]  HPROT;
   logic        HWRITE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;

   modport master (
      output HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
      input  HREADYOUT, HRESP, HRDATA
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
      output HREADYOUT, HRESP, HRDATA
   );
endinterface

// File: rtl/ahblite_uart.sv
// AHB-Lite UART: 8N1 TX/RX with small FIFOs, programmable bit divisor and a level IRQ.
// Zero-wait-state register map: DATA, STATUS, BAUDDIV, CTRL.
module ahblite_uart #(
   parameter int unsigned FIFO_DEPTH      = 4,
   parameter logic [15:0] DEFAULT_BAUDDIV = 16'd434
) (
   input  logic          clk,
   input  logic          RSTn,
   ahblite_uart_if.slave bus,
   input  logic          RXD,
   output logic          TXD,
   output logic          interrupt_UART
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] Depth = CntW'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_st_e;

   // Bus and register state
   logic        ahb_acc, rd_acc;
   logic [1:0]  addr_q, addr_d;
   logic        wr_q, wr_d;
   logic [31:0] rdata_q, rdata_d;
   logic [15:0] baud_q, baud_d;
   logic [1:0]  ctrl_q, ctrl_d;
   logic        ovr_q, ovr_d, ferr_q, ferr_d;
   logic        wr_data, wr_status, wr_baud, wr_ctrl;
   logic [31:0] status;

   // FIFOs
   logic [7:0]      tx_mem_q [FIFO_DEPTH];
   logic [7:0]      tx_mem_d [FIFO_DEPTH];
   logic [7:0]      rx_mem_q [FIFO_DEPTH];
   logic [7:0]      rx_mem_d [FIFO_DEPTH];
   logic [PtrW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   logic [PtrW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic [CntW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic            tx_push, tx_pop, rx_push, rx_pop;
   logic            tx_full, tx_empty, rx_full, rx_empty;

   // TX engine
   uart_st_e    tx_st_q, tx_st_d;
   logic [15:0] tx_tick_q, tx_tick_d, tx_div_q, tx_div_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_sh_q, tx_sh_d;
   logic        txd_q, txd_d;
   logic        tx_bit_end, tx_busy;

   // RX engine
   logic        rx_s1_q, rx_s2_q, rx_prev_q;
   uart_st_e    rx_st_q, rx_st_d;
   logic [15:0] rx_tick_q, rx_tick_d, rx_div_q, rx_div_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_sh_q, rx_sh_d;
   logic        rx_sample, rx_ovr_set, rx_ferr_set;

   logic unused_bus;
   assign unused_bus = ^{bus.HSIZE, bus.HPROT, bus.HADDR[31:4], bus.HADDR[1:0],
                         bus.HWDATA[31:16]};

   assign ahb_acc = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
   assign rd_acc  = ahb_acc & ~bus.HWRITE;

   assign wr_data   = wr_q & (addr_q == 2'd0);
   assign wr_status = wr_q & (addr_q == 2'd1);
   assign wr_baud   = wr_q & (addr_q == 2'd2);
   assign wr_ctrl   = wr_q & (addr_q == 2'd3);

   assign tx_full  = (tx_cnt_q == Depth);
   assign tx_empty = (tx_cnt_q == '0);
   assign rx_full  = (rx_cnt_q == Depth);
   assign rx_empty = (rx_cnt_q == '0);
   assign tx_busy  = (tx_st_q != StIdle);

   assign tx_push = wr_data & ~tx_full;
   assign rx_pop  = rd_acc & (bus.HADDR[3:2] == 2'd0) & ~rx_empty;

   assign status = {25'd0, ferr_q, tx_busy, ovr_q, rx_full, rx_empty, tx_empty, tx_full};

   assign bus.HREADYOUT = 1'b1;
   assign bus.HRESP     = 1'b0;
   assign bus.HRDATA    = rdata_q;
   assign TXD           = txd_q;
   assign interrupt_UART = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty);

   // Bus pipeline and registers; read data is captured at the address-phase edge
   always_comb begin
      addr_d  = ahb_acc ? bus.HADDR[3:2] : addr_q;
      wr_d    = ahb_acc & bus.HWRITE;
      rdata_d = rdata_q;
      if (rd_acc) begin
         unique case (bus.HADDR[3:2])
            2'd0:    rdata_d = rx_empty ? 32'd0 : {24'd0, rx_mem_q[rx_rp_q]};
            2'd1:    rdata_d = status;
            2'd2:    rdata_d = {16'd0, baud_q};
            default: rdata_d = {30'd0, ctrl_q};
         endcase
      end
      baud_d = baud_q;
      if (wr_baud) baud_d = (bus.HWDATA[15:0] < 16'd4) ? 16'd4 : bus.HWDATA[15:0];
      ctrl_d = wr_ctrl ? bus.HWDATA[1:0] : ctrl_q;
      // A new event wins over a same-cycle clear so it is never lost
      ovr_d = (wr_status & bus.HWDATA[4]) ? 1'b0 : ovr_q;
      if (rx_ovr_set) ovr_d = 1'b1;
      ferr_d = (wr_status & bus.HWDATA[6]) ? 1'b0 : ferr_q;
      if (rx_ferr_set) ferr_d = 1'b1;
   end

   always_comb begin
      tx_mem_d = tx_mem_q;
      rx_mem_d = rx_mem_q;
      if (tx_push) tx_mem_d[tx_wp_q] = bus.HWDATA[7:0];
      if (rx_push) rx_mem_d[rx_wp_q] = rx_sh_q;
      tx_wp_d = tx_push ? tx_wp_q + PtrW'(1) : tx_wp_q;
      tx_rp_d = tx_pop  ? tx_rp_q + PtrW'(1) : tx_rp_q;
      rx_wp_d = rx_push ? rx_wp_q + PtrW'(1) : rx_wp_q;
      rx_rp_d = rx_pop  ? rx_rp_q + PtrW'(1) : rx_rp_q;
      tx_cnt_d = tx_cnt_q;
      if (tx_push & ~tx_pop) tx_cnt_d = tx_cnt_q + CntW'(1);
      if (~tx_push & tx_pop) tx_cnt_d = tx_cnt_q - CntW'(1);
      rx_cnt_d = rx_cnt_q;
      if (rx_push & ~rx_pop) rx_cnt_d = rx_cnt_q + CntW'(1);
      if (~rx_push & rx_pop) rx_cnt_d = rx_cnt_q - CntW'(1);
   end

   // TX: the divisor is re-latched at every bit boundary
   always_comb begin
      tx_st_d    = tx_st_q;
      tx_tick_d  = tx_tick_q;
      tx_div_d   = tx_div_q;
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      txd_d      = txd_q;
      tx_pop     = 1'b0;
      tx_bit_end = (tx_tick_q == tx_div_q - 16'd1);
      if (tx_st_q != StIdle) begin
         tx_tick_d = tx_tick_q + 16'd1;
         if (tx_bit_end) begin
            tx_tick_d = 16'd0;
            tx_div_d  = baud_q;
         end
      end
      unique case (tx_st_q)
         StIdle: begin
            txd_d = 1'b1;
            if (!tx_empty) begin
               tx_pop    = 1'b1;
               tx_sh_d   = tx_mem_q[tx_rp_q];
               tx_st_d   = StStart;
               tx_tick_d = 16'd0;
               tx_div_d  = baud_q;
               txd_d     = 1'b0;
            end
         end
         StStart: begin
            if (tx_bit_end) begin
               tx_st_d  = StData;
               tx_bit_d = 3'd0;
               txd_d    = tx_sh_q[0];
            end
         end
         StData: begin
            if (tx_bit_end) begin
               if (tx_bit_q == 3'd7) begin
                  tx_st_d = StStop;
                  txd_d   = 1'b1;
               end else begin
                  tx_bit_d = tx_bit_q + 3'd1;
                  tx_sh_d  = tx_sh_q >> 1;
                  txd_d    = tx_sh_q[1];
               end
            end
         end
         default: begin
            if (tx_bit_end) begin
               if (!tx_empty) begin
                  tx_pop  = 1'b1;
                  tx_sh_d = tx_mem_q[tx_rp_q];
                  tx_st_d = StStart;
                  txd_d   = 1'b0;
               end else begin
                  tx_st_d = StIdle;
                  txd_d   = 1'b1;
               end
            end
         end
      endcase
   end

   // RX: first wait is half a bit so later samples land mid-bit
   always_comb begin
      rx_st_d     = rx_st_q;
      rx_tick_d   = rx_tick_q;
      rx_div_d    = rx_div_q;
      rx_bit_d    = rx_bit_q;
      rx_sh_d     = rx_sh_q;
      rx_push     = 1'b0;
      rx_ovr_set  = 1'b0;
      rx_ferr_set = 1'b0;
      rx_sample   = (rx_tick_q == rx_div_q - 16'd1);
      if (rx_st_q != StIdle) begin
         rx_tick_d = rx_tick_q + 16'd1;
         if (rx_sample) begin
            rx_tick_d = 16'd0;
            rx_div_d  = baud_q;
         end
      end
      unique case (rx_st_q)
         StIdle: begin
            if (rx_prev_q & ~rx_s2_q) begin
               rx_st_d   = StStart;
               rx_tick_d = 16'd0;
               rx_div_d  = {1'b0, baud_q[15:1]};
            end
         end
         StStart: begin
            if (rx_sample) begin
               rx_st_d  = rx_s2_q ? StIdle : StData;
               rx_bit_d = 3'd0;
            end
         end
         StData: begin
            if (rx_sample) begin
               rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
               rx_bit_d = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_st_d = StStop;
            end
         end
         default: begin
            if (rx_sample) begin
               rx_st_d     = StIdle;
               rx_push     = rx_s2_q & ~rx_full;
               rx_ovr_set  = rx_s2_q & rx_full;
               rx_ferr_set = ~rx_s2_q;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      tx_mem_q <= tx_mem_d;
      rx_mem_q <= rx_mem_d;
   end

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         addr_q    <= 2'd0;
         wr_q      <= 1'b0;
         rdata_q   <= 32'd0;
         baud_q    <= DEFAULT_BAUDDIV;
         ctrl_q    <= 2'd0;
         ovr_q     <= 1'b0;
         ferr_q    <= 1'b0;
         tx_wp_q   <= '0;
         tx_rp_q   <= '0;
         tx_cnt_q  <= '0;
         rx_wp_q   <= '0;
         rx_rp_q   <= '0;
         rx_cnt_q  <= '0;
         tx_st_q   <= StIdle;
         tx_tick_q <= 16'd0;
         tx_div_q  <= DEFAULT_BAUDDIV;
         tx_bit_q  <= 3'd0;
         tx_sh_q   <= 8'd0;
         txd_q     <= 1'b1;
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
         rx_st_q   <= StIdle;
         rx_tick_q <= 16'd0;
         rx_div_q  <= DEFAULT_BAUDDIV;
         rx_bit_q  <= 3'd0;
         rx_sh_q   <= 8'd0;
      end else begin
         addr_q    <= addr_d;
         wr_q      <= wr_d;
         rdata_q   <= rdata_d;
         baud_q    <= baud_d;
         ctrl_q    <= ctrl_d;
         ovr_q     <= ovr_d;
         ferr_q    <= ferr_d;
         tx_wp_q   <= tx_wp_d;
         tx_rp_q   <= tx_rp_d;
         tx_cnt_q  <= tx_cnt_d;
         rx_wp_q   <= rx_wp_d;
         rx_rp_q   <= rx_rp_d;
         rx_cnt_q  <= rx_cnt_d;
         tx_st_q   <= tx_st_d;
         tx_tick_q <= tx_tick_d;
         tx_div_q  <= tx_div_d;
         tx_bit_q  <= tx_bit_d;
         tx_sh_q   <= tx_sh_d;
         txd_q     <= txd_d;
         rx_s1_q   <= RXD;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
         rx_st_q   <= rx_st_d;
         rx_tick_q <= rx_tick_d;
         rx_div_q  <= rx_div_d;
         rx_bit_q  <= rx_bit_d;
         rx_sh_q   <= rx_sh_d;
      end
   end

endmodule

// File: tb/tb_ahblite_uart.sv
// Directed bench for ahblite_uart: register map, TX/RX framing, FIFO limits, sticky flags.
module tb_ahblite_uart;
   logic clk = 1'b0;
   logic RSTn;
   logic RXD;
   logic TXD;
   logic irq;
   int   n_cmp = 0;
   int   n_err = 0;

   ahblite_uart_if bus_if ();

   ahblite_uart #(
      .FIFO_DEPTH     (4),
      .DEFAULT_BAUDDIV(16'd434)
   ) dut (
      .clk           (clk),
      .RSTn          (RSTn),
      .bus           (bus_if.slave),
      .RXD           (RXD),
      .TXD           (TXD),
      .interrupt_UART(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic bus_idle();
      bus_if.HSEL   = 1'b0;
      bus_if.HTRANS = 2'b00;
      bus_if.HWRITE = 1'b0;
   endtask

   task automatic ahb_write(input logic [3:0] a, input logic [31:0] d);
      bus_if.HSEL   = 1'b1;
      bus_if.HTRANS = 2'b10;
      bus_if.HWRITE = 1'b1;
      bus_if.HADDR  = {28'd0, a};
      @(posedge clk); #1;
      bus_idle();
      bus_if.HWDATA = d;
      @(posedge clk); #1;
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
      bus_if.HSEL   = 1'b1;
      bus_if.HTRANS = 2'b10;
      bus_if.HWRITE = 1'b0;
      bus_if.HADDR  = {28'd0, a};
      @(posedge clk); #1;
      bus_idle();
      chk(tag, bus_if.HRDATA, exp);
   endtask

   // One 8N1 frame at 8 clocks per bit
   task automatic send_frame(input logic [7:0] b, input logic stop);
      RXD = 1'b0;
      repeat (8) @(posedge clk); #1;
      for (int i = 0; i < 8; i++) begin
         RXD = b[i];
         repeat (8) @(posedge clk); #1;
      end
      RXD = stop;
      repeat (8) @(posedge clk); #1;
      RXD = 1'b1;
   endtask

   initial begin
      logic [7:0] tb_byte;
      logic       exp_bit;

      RSTn          = 1'b0;
      RXD           = 1'b1;
      bus_idle();
      bus_if.HADDR  = 32'd0;
      bus_if.HWDATA = 32'd0;
      bus_if.HSIZE  = 3'b010;
      bus_if.HPROT  = 4'd0;
      bus_if.HREADY = 1'b1;
      repeat (2) @(posedge clk); #1;
      chk("reset_txd", {31'd0, TXD}, 32'd1);
      chk("reset_hrdata", bus_if.HRDATA, 32'd0);
      chk("reset_hreadyout", {31'd0, bus_if.HREADYOUT}, 32'd1);
      chk("reset_hresp", {31'd0, bus_if.HRESP}, 32'd0);
      chk("reset_irq", {31'd0, irq}, 32'd0);
      RSTn = 1'b1;
      @(posedge clk); #1;

      rd_chk("baud_reset", 4'h8, 32'h0000_01B2);
      rd_chk("status_reset", 4'h4, 32'h06);
      rd_chk("ctrl_reset", 4'hC, 32'h0);
      ahb_write(4'h8, 32'd1);
      rd_chk("baud_min_clamp", 4'h8, 32'd4);
      ahb_write(4'h8, 32'd8);
      rd_chk("baud_8", 4'h8, 32'd8);

      // TX one byte; TXD checked at the first cycle of every bit
      ahb_write(4'hC, 32'h2);
      chk("irq_tx_idle", {31'd0, irq}, 32'd1);
      ahb_write(4'h0, 32'hA5);
      chk("irq_tx_pending", {31'd0, irq}, 32'd0);
      chk("txd_before_pop", {31'd0, TXD}, 32'd1);
      @(posedge clk); #1;
      tb_byte = 8'hA5;
      for (int b = 0; b < 10; b++) begin
         if (b == 0) exp_bit = 1'b0;
         else if (b == 9) exp_bit = 1'b1;
         else exp_bit = tb_byte[b-1];
         chk($sformatf("tx_a5_bit%0d", b), {31'd0, TXD}, {31'd0, exp_bit});
         if (b < 9) begin
            repeat (8) @(posedge clk); #1;
         end
      end
      repeat (7) @(posedge clk); #1;
      rd_chk("tx_busy_last_cycle", 4'h4, 32'h26);
      rd_chk("tx_idle_after_frame", 4'h4, 32'h06);
      chk("txd_idle", {31'd0, TXD}, 32'd1);
      chk("irq_tx_drained", {31'd0, irq}, 32'd1);
      ahb_write(4'hC, 32'h0);

      // RX one byte
      send_frame(8'h3C, 1'b1);
      rd_chk("rx_status_avail", 4'h4, 32'h02);
      rd_chk("rx_data_3c", 4'h0, 32'h3C);
      rd_chk("rx_data_empty", 4'h0, 32'h0);
      rd_chk("rx_status_empty", 4'h4, 32'h06);

      // RX overrun with 5 frames into a 4-entry FIFO
      for (int i = 0; i < 5; i++) begin
         tb_byte = 8'(17 * (i + 1));
         send_frame(tb_byte, 1'b1);
      end
      rd_chk("ovr_status", 4'h4, 32'h1A);
      for (int i = 0; i < 4; i++) begin
         rd_chk($sformatf("ovr_data%0d", i), 4'h0, 32'(17 * (i + 1)));
      end
      rd_chk("ovr_sticky", 4'h4, 32'h16);
      ahb_write(4'h4, 32'h10);
      rd_chk("ovr_cleared", 4'h4, 32'h06);

      // Framing error
      send_frame(8'h55, 1'b0);
      repeat (4) @(posedge clk); #1;
      rd_chk("ferr_status", 4'h4, 32'h46);
      ahb_write(4'h4, 32'h40);
      rd_chk("ferr_cleared", 4'h4, 32'h06);

      // False start glitch
      RXD = 1'b0;
      repeat (2) @(posedge clk); #1;
      RXD = 1'b1;
      repeat (20) @(posedge clk); #1;
      rd_chk("glitch_status", 4'h4, 32'h06);

      // TX FIFO overflow: 6 pipelined writes, 5 contiguous frames expected
      ahb_write(4'h8, 32'd100);
      for (int i = 0; i < 7; i++) begin
         if (i < 6) begin
            bus_if.HSEL   = 1'b1;
            bus_if.HTRANS = 2'b10;
            bus_if.HWRITE = 1'b1;
            bus_if.HADDR  = 32'h0;
         end else begin
            bus_idle();
         end
         if (i > 0) bus_if.HWDATA = 32'(i);
         @(posedge clk); #1;
      end
      repeat (46) @(posedge clk); #1;
      for (int f = 0; f < 5; f++) begin
         tb_byte = 8'(f + 1);
         for (int j = 0; j < 10; j++) begin
            if (j == 0) exp_bit = 1'b0;
            else if (j == 9) exp_bit = 1'b1;
            else exp_bit = tb_byte[j-1];
            chk($sformatf("txfull_f%0d_b%0d", f, j), {31'd0, TXD}, {31'd0, exp_bit});
            repeat (100) @(posedge clk); #1;
         end
      end
      chk("txfull_sixth_dropped", {31'd0, TXD}, 32'd1);
      rd_chk("txfull_idle_status", 4'h4, 32'h06);

      // Asynchronous reset mid-frame
      ahb_write(4'h8, 32'd8);
      ahb_write(4'h0, 32'h00);
      repeat (5) @(posedge clk); #1;
      chk("midframe_txd_low", {31'd0, TXD}, 32'd0);
      #3;
      RSTn = 1'b0;
      #1;
      chk("async_reset_txd", {31'd0, TXD}, 32'd1);
      @(posedge clk); #1;
      RSTn = 1'b1;
      @(posedge clk); #1;
      rd_chk("post_reset_status", 4'h4, 32'h06);
      rd_chk("post_reset_baud", 4'h8, 32'h0000_01B2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
